mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 36 +++
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : Single-port mem_req/mem_write memory bus between one
//                initiator (master) and the mem_responder target (slave).
//                Carries the request fields, the read-data strobe and the
//                responder status/debug outputs.
//  Ports       : none (clk/rst are plain ports on the modules)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if #(
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 32,
    parameter int CNT_W  = 16
) ();
    logic              mem_req;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic [MEM_DW-1:0] mem_wdata;
    logic              mem_rdata_vld;
    logic [MEM_DW-1:0] mem_rdata;
    logic              busy;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;

    modport master (
        output mem_req, mem_write, mem_addr, mem_wdata,
        input  mem_rdata_vld, mem_rdata, busy, wr_cnt, rd_cnt
    );

    modport slave (
        input  mem_req, mem_write, mem_addr, mem_wdata,
        output mem_rdata_vld, mem_rdata, busy, wr_cnt, rd_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Target side of the mem_req/mem_write bus. Owns a word RAM,
//                performs single-cycle writes and returns read data with a
//                fixed latency of READ_LAT cycles through a one-cycle
//                mem_rdata_vld strobe. Keeps wrapping write/read counters.
//  Ports       : clk_i-style plain ports clk, rst (sync, active high);
//                bus (slave modport): mem_req, mem_write, mem_addr,
//                mem_wdata in; mem_rdata_vld, mem_rdata, busy, wr_cnt,
//                rd_cnt out.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int MEM_AW   = 16,
    parameter int MEM_DW   = 32,
    parameter int DEPTH_AW = 10,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_responder_if.slave bus
);

    localparam int DEPTH = 1 << DEPTH_AW;
    // Holds READ_LAT-1 down to 1; at least one bit so READ_LAT=1 still elaborates.
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   wr_cnt_q;
    logic [CNT_W-1:0]   rd_cnt_q;
    logic [MEM_DW-1:0]  data_q;      // word captured at read acceptance
    logic [MEM_DW-1:0]  last_q;      // value shown on mem_rdata outside RESP
    logic [MEM_DW-1:0]  ram_q [0:DEPTH-1];

    logic               wr_en;
    logic               rd_en;
    logic [DEPTH_AW-1:0] idx;
    logic               unused_addr_bits;

    // Upper address bits alias onto the RAM, so only the low bits index it.
    assign idx              = bus.mem_addr[DEPTH_AW-1:0];
    assign unused_addr_bits = ^bus.mem_addr;

    // Requests are only accepted in IDLE; WAIT/RESP ignore the bus entirely.
    assign wr_en = !rst && (state_q == S_IDLE) && bus.mem_req &&  bus.mem_write;
    assign rd_en = !rst && (state_q == S_IDLE) && bus.mem_req && !bus.mem_write;

    // RAM and read capture are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_q[idx] <= bus.mem_wdata;
        end
        if (rd_en) begin
            data_q <= ram_q[idx];
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (rd_en) begin
                    if (READ_LAT == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        lat_d   = LAT_W'(READ_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lat_q    <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            last_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (wr_en) begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
            if (state_q == S_RESP) begin
                rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                last_q   <= data_q;
            end
        end
    end

    // data_q is presented only during RESP so mem_rdata does not change
    // when a new read is accepted, only when its strobe arrives.
    assign bus.mem_rdata_vld = (state_q == S_RESP);
    assign bus.mem_rdata     = (state_q == S_RESP) ? data_q : last_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.wr_cnt        = wr_cnt_q;
    assign bus.rd_cnt        = rd_cnt_q;

    a_write_known : assert property (@(posedge clk) disable iff (rst)
        bus.mem_req |-> !$isunknown(bus.mem_write));

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Bench for mem_responder. DUT A uses READ_LAT=2/CNT_W=16,
//                DUT B uses READ_LAT=1/CNT_W=4. A transaction-level model
//                (memory array + accepted-read timestamps) predicts every
//                output each cycle; directed steps add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic chk_en = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    mem_responder_if #(.MEM_AW(16), .MEM_DW(32), .CNT_W(16)) a_if ();
    mem_responder_if #(.MEM_AW(16), .MEM_DW(32), .CNT_W(4))  b_if ();

    mem_responder #(.MEM_AW(16), .MEM_DW(32), .DEPTH_AW(10), .READ_LAT(2), .CNT_W(16))
        u_dut_a (.clk(clk), .rst(rst_a), .bus(a_if.slave));
    mem_responder #(.MEM_AW(16), .MEM_DW(32), .DEPTH_AW(10), .READ_LAT(1), .CNT_W(4))
        u_dut_b (.clk(clk), .rst(rst_b), .bus(b_if.slave));

    // ---------------- model ----------------
    int          n_m   [2];
    int          a_m   [2];      // edge number at which the latest read was accepted
    bit          have_m[2];
    int          wr_m  [2];
    int          rd_m  [2];
    logic [31:0] rdm_m [2];
    bit          rdk_m [2];
    logic [31:0] last_m[2];
    bit          lastk_m[2];
    logic [31:0] mem_m [2][1024];
    bit          known_m[2][1024];

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int cmask(input int d);
        return (d == 0) ? 32'hFFFF : 32'hF;
    endfunction

    task automatic model_step(input int d, input logic r, input logic req, input logic wr,
                              input logic [15:0] addr, input logic [31:0] wd);
        int L;
        int idx;
        L   = lat_of(d);
        idx = int'(addr[9:0]);
        n_m[d]++;
        if (r) begin
            have_m[d] = 1'b0; wr_m[d] = 0; rd_m[d] = 0;
            last_m[d] = '0;   lastk_m[d] = 1'b1;
        end else begin
            // The edge L after acceptance closes the strobe cycle.
            if (have_m[d] && n_m[d] == a_m[d] + L) begin
                rd_m[d]++;
                last_m[d]  = rdm_m[d];
                lastk_m[d] = rdk_m[d];
            end
            if ((!have_m[d] || n_m[d] > a_m[d] + L) && req) begin
                if (wr) begin
                    mem_m[d][idx]   = wd;
                    known_m[d][idx] = 1'b1;
                    wr_m[d]++;
                end else begin
                    have_m[d] = 1'b1;
                    a_m[d]    = n_m[d];
                    rdm_m[d]  = mem_m[d][idx];
                    rdk_m[d]  = known_m[d][idx];
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_a, a_if.mem_req, a_if.mem_write, a_if.mem_addr, a_if.mem_wdata);
        model_step(1, rst_b, b_if.mem_req, b_if.mem_write, b_if.mem_addr, b_if.mem_wdata);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic get_out(input int d, output logic vld, output logic bsy,
                           output logic [31:0] rdata, output logic [31:0] wrc,
                           output logic [31:0] rdc);
        if (d == 0) begin
            vld = a_if.mem_rdata_vld; bsy = a_if.busy; rdata = a_if.mem_rdata;
            wrc = 32'(a_if.wr_cnt);   rdc = 32'(a_if.rd_cnt);
        end else begin
            vld = b_if.mem_rdata_vld; bsy = b_if.busy; rdata = b_if.mem_rdata;
            wrc = 32'(b_if.wr_cnt);   rdc = 32'(b_if.rd_cnt);
        end
    endtask

    task automatic compare_dut(input int d);
        logic        vld, bsy, vld_e, bsy_e;
        logic [31:0] rdata, wrc, rdc;
        int          L;
        L     = lat_of(d);
        get_out(d, vld, bsy, rdata, wrc, rdc);
        vld_e = have_m[d] && (n_m[d] == a_m[d] + L - 1);
        bsy_e = have_m[d] && (n_m[d] <= a_m[d] + L - 1);
        check($sformatf("dut%0d.vld", d),  32'(vld), 32'(vld_e));
        check($sformatf("dut%0d.busy", d), 32'(bsy), 32'(bsy_e));
        check($sformatf("dut%0d.wr_cnt", d), wrc, wr_m[d] & cmask(d));
        check($sformatf("dut%0d.rd_cnt", d), rdc, rd_m[d] & cmask(d));
        if (vld_e && rdk_m[d])
            check($sformatf("dut%0d.rdata", d), rdata, rdm_m[d]);
        else if (!vld_e && lastk_m[d])
            check($sformatf("dut%0d.rdata_hold", d), rdata, last_m[d]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare_dut(0);
            compare_dut(1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input int d, input logic req, input logic wr,
                       input logic [15:0] addr, input logic [31:0] wd);
        if (d == 0) begin
            a_if.mem_req = req; a_if.mem_write = wr; a_if.mem_addr = addr; a_if.mem_wdata = wd;
        end else begin
            b_if.mem_req = req; b_if.mem_write = wr; b_if.mem_addr = addr; b_if.mem_wdata = wd;
        end
    endtask

    task automatic do_write(input int d, input logic [15:0] addr, input logic [31:0] wd);
        drv(d, 1'b1, 1'b1, addr, wd);
        @(negedge clk);
        drv(d, 1'b0, 1'b0, addr, wd);
    endtask

    // Request held until the strobe, dropped during the strobe cycle, and the
    // task returns in the following IDLE cycle.
    task automatic do_read(input int d, input logic [15:0] addr,
                           input logic [31:0] exp_data, input int exp_lat);
        logic        vld, bsy;
        logic [31:0] rdata, wrc, rdc;
        int          k;
        bit          got;
        k = 0; got = 1'b0;
        drv(d, 1'b1, 1'b0, addr, 32'h0);
        while (k < 10 && !got) begin
            @(negedge clk);
            k++;
            get_out(d, vld, bsy, rdata, wrc, rdc);
            if (vld) got = 1'b1;
        end
        if (!got) begin
            check("read_timeout", 32'd0, 32'd1);
        end else begin
            check("read_latency", 32'(k), 32'(exp_lat));
            check("read_data", rdata, exp_data);
        end
        drv(d, 1'b0, 1'b0, addr, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        logic        vld, bsy;
        logic [31:0] rdata, wrc, rdc;

        rst_a = 1'b1; rst_b = 1'b1;
        drv(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        get_out(0, vld, bsy, rdata, wrc, rdc);
        check("reset_vld", 32'(vld), 32'd0);
        check("reset_busy", 32'(bsy), 32'd0);
        check("reset_wr_cnt", wrc, 32'd0);
        check("reset_rd_cnt", rdc, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Single write then read at READ_LAT=2
        do_write(0, 16'h0005, 32'hDEADBEEF);
        get_out(0, vld, bsy, rdata, wrc, rdc);
        check("first_write_wr_cnt", wrc, 32'd1);
        do_read(0, 16'h0005, 32'hDEADBEEF, 2);
        get_out(0, vld, bsy, rdata, wrc, rdc);
        check("first_read_rd_cnt", rdc, 32'd1);

        // Burst of writes with req held high, then back-to-back reads
        for (int i = 1; i <= 4; i++) begin
            drv(0, 1'b1, 1'b1, 16'(i), ~32'(i));
            @(negedge clk);
        end
        drv(0, 1'b0, 1'b0, 16'h0, 32'h0);
        get_out(0, vld, bsy, rdata, wrc, rdc);
        check("burst_wr_cnt", wrc, 32'd5);
        do_read(0, 16'h0001, 32'hFFFFFFFE, 2);
        do_read(0, 16'h0002, 32'hFFFFFFFD, 2);
        do_read(0, 16'h0003, 32'hFFFFFFFC, 2);
        do_read(0, 16'h0004, 32'hFFFFFFFB, 2);
        get_out(0, vld, bsy, rdata, wrc, rdc);
        check("burst_rd_cnt", rdc, 32'd5);

        // Aliasing modulo 2^10
        do_write(0, 16'h0403, 32'h00000011);
        do_read(0, 16'h0003, 32'h00000011, 2);

        // Reset during WAIT aborts the read
        drv(0, 1'b1, 1'b0, 16'h0005, 32'h0);
        @(negedge clk);
        get_out(0, vld, bsy, rdata, wrc, rdc);
        check("wait_busy", 32'(bsy), 32'd1);
        check("wait_vld", 32'(vld), 32'd0);
        rst_a = 1'b1;
        drv(0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        get_out(0, vld, bsy, rdata, wrc, rdc);
        check("abort_busy", 32'(bsy), 32'd0);
        check("abort_rd_cnt", rdc, 32'd0);
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            get_out(0, vld, bsy, rdata, wrc, rdc);
            check("abort_no_vld", 32'(vld), 32'd0);
        end
        do_read(0, 16'h0005, 32'hDEADBEEF, 2);
        get_out(0, vld, bsy, rdata, wrc, rdc);
        check("after_abort_rd_cnt", rdc, 32'd1);

        // READ_LAT=1: write then read same address on consecutive cycles
        do_write(1, 16'h0007, 32'hA5A5A5A5);
        do_read(1, 16'h0007, 32'hA5A5A5A5, 1);
        do_read(1, 16'h0407, 32'hA5A5A5A5, 1);

        // CNT_W=4 wrap: 17 writes in total
        for (int i = 0; i < 16; i++) begin
            drv(1, 1'b1, 1'b1, 16'(i + 16), 32'(i * 3));
            @(negedge clk);
        end
        drv(1, 1'b0, 1'b0, 16'h0, 32'h0);
        get_out(1, vld, bsy, rdata, wrc, rdc);
        check("wrap_wr_cnt", wrc, 32'd1);
        check("b_rd_cnt", rdc, 32'd2);
        do_read(1, 16'h001F, 32'd45, 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
